// File: rtl/inv_sub_shift_ark.sv
// inv_sub_shift_ark: iterative AES-128 decrypt-round front end.
//   out_state = InvSubBytes(InvShiftRows(in_state)) ^ in_key
// State byte k occupies bits [8k:8k+7] of a [0:127] vector (row k%4, column k/4).
// The inverse S-box is computed (inverse affine, then GF(2^8) inverse).
// SBOX_LANES copies of it process SBOX_LANES bytes per cycle. Legal values are 4, 8 and 16.
// Optional feature: define ISSA_BLK_CNT_EN to add a 16-bit completed-block counter port blk_cnt.
module inv_sub_shift_ark #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic [0:127] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         out_last
`ifdef ISSA_BLK_CNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    localparam int NCYC  = 16 / SBOX_LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [0:127]     work_r;
    logic [0:127]     key_r;
    logic             last_r;
    logic [0:127]     work_next_s;
    int               lane_base_s;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (aa & {8{b[i]}});
            aa  = {aa[6:0], 1'b0} ^ (8'h1b & {8{aa[7]}});
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    // Row r is rotated right by r columns: out(r,c) = in(r,(c-r) mod 4)
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] t;
        t = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[7'(8 * (4 * c + r)) +: 8] = s[7'(8 * (4 * ((c - r + 4) % 4) + r)) +: 8];
            end
        end
        return t;
    endfunction

    // A new block is taken only in IDLE and never while reset is held
    assign in_ready    = (state_r == ST_IDLE) && reset;
    assign lane_base_s = int'(cnt_r) * SBOX_LANES;

    // Substitute and key-mix the lane group selected by cnt into a copy of the state
    always_comb begin
        logic [6:0] pos;
        work_next_s = work_r;
        pos         = 7'd0;
        for (int i = 0; i < SBOX_LANES; i++) begin
            pos = 7'(8 * (lane_base_s + i));
            work_next_s[pos +: 8] = inv_sbox(work_r[pos +: 8]) ^ key_r[pos +: 8];
        end
    end

    // Round FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            work_r    <= 128'h0;
            key_r     <= 128'h0;
            last_r    <= 1'b0;
            out_valid <= 1'b0;
            out_state <= 128'h0;
            out_last  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_r  <= inv_shift_rows(in_state);
                        key_r   <= in_key;
                        last_r  <= in_last;
                        cnt_r   <= '0;
                        state_r <= ST_SUB;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SUB: begin
                    work_r <= work_next_s;
                    if (cnt_r == CNT_LAST) begin
                        // Counter parks at its last value so it never wraps
                        state_r   <= ST_DONE;
                        out_valid <= 1'b1;
                        out_state <= work_next_s;
                        out_last  <= last_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ISSA_BLK_CNT_EN
    // Count delivered blocks; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt <= 16'h0000;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 16'h0001;
        end else begin
            blk_cnt <= blk_cnt;
        end
    end
`endif

endmodule
